// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: 2-flop synchronisers, one shared sample tick,
// and a per-channel stability counter that must see STABLE_COUNT disagreeing ticks.
module multi_debouncer #(
  parameter int   CHANNELS     = 4,
  parameter int   THRESHOLD    = 50,
  parameter int   STABLE_COUNT = 7,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] buttonIn,
  output logic [CHANNELS-1:0] buttonOut,
  output logic [CHANNELS-1:0] risingEdge,
  output logic [CHANNELS-1:0] fallingEdge,
  output logic                tick
);

  localparam int TW = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(THRESHOLD - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_COUNT - 1);
  localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

  logic [CHANNELS-1:0]         sync1_q, sync2_q;
  logic [TW-1:0]               tick_cnt_q, tick_cnt_d;
  logic [CHANNELS-1:0][CW-1:0] stab_q, stab_d;
  logic [CHANNELS-1:0]         out_q, out_d;
  logic [CHANNELS-1:0]         rise_q, rise_d;
  logic [CHANNELS-1:0]         fall_q, fall_d;

  assign tick = enable && (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (enable) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end
  end

  // Channel state only moves on a tick; edge pulses are produced alongside the output flip.
  always_comb begin
    stab_d = stab_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tick) begin
        if (sync2_q[i] == out_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == STAB_LAST) begin
          stab_d[i] = '0;
          out_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= INIT_VEC;
      sync2_q    <= INIT_VEC;
      tick_cnt_q <= '0;
      stab_q     <= '0;
      out_q      <= INIT_VEC;
      rise_q     <= '0;
      fall_q     <= '0;
    end else begin
      sync1_q    <= buttonIn;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      stab_q     <= stab_d;
      out_q      <= out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign buttonOut   = out_q;
  assign risingEdge  = rise_q;
  assign fallingEdge = fall_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: predicted edge pulses are queued when a
// button step is driven and matched against the pulses the debouncer emits.
module tb_multi_debouncer;

  localparam int THR    = 4;
  localparam int STABLE = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] buttonIn = 2'b00;
  logic [1:0] buttonOut, risingEdge, fallingEdge;
  logic       tick;

  typedef struct {
    int         due;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] out;
  } exp_t;

  exp_t       sbQ[$];
  int         passCnt = 0;
  int         failCnt = 0;
  int         totalCnt = 0;
  int         cyc = 0;
  int         tphase = 0;
  logic [1:0] modelOut = 2'b00;

  multi_debouncer #(
    .CHANNELS(2), .THRESHOLD(THR), .STABLE_COUNT(STABLE), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .buttonIn(buttonIn),
    .buttonOut(buttonOut), .risingEdge(risingEdge), .fallingEdge(fallingEdge),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First tick seeing the new synchronised level is at least 2 cycles after the drive.
  function automatic int predictDue(input int c, input int p);
    int j = 2;
    while ((p + j) % THR != THR - 1) j++;
    return c + j + THR * (STABLE - 1) + 1;
  endfunction

  task automatic pushExpected(input logic [1:0] val);
    exp_t e;
    if (val != modelOut) begin
      e.due  = predictDue(cyc, tphase);
      e.rise = val & ~modelOut;
      e.fall = ~val & modelOut;
      e.out  = val;
      sbQ.push_back(e);
      modelOut = val;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] val);
    @(negedge clk); #1;
    buttonIn = val;
    pushExpected(val);
  endtask

  task automatic drainScoreboard();
    int budget = 40;
    while (sbQ.size() != 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    checkOutput("drain", sbQ.size(), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) tphase <= 0;
    else if (enable) tphase <= (tphase == THR - 1) ? 0 : tphase + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    checkOutput("tick", tick, reset_n && enable && (tphase == THR - 1));
    checkOutput("edge_exclusive", risingEdge & fallingEdge, 0);
    if (sbQ.size() > 0 && cyc > sbQ[0].due) begin
      checkOutput("pulse_missing_at", cyc, sbQ[0].due);
      void'(sbQ.pop_front());
    end
    if ((risingEdge | fallingEdge) != 2'b00) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_pulse", {risingEdge, fallingEdge}, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("pulse_cycle", cyc, e.due);
        checkOutput("risingEdge", risingEdge, e.rise);
        checkOutput("fallingEdge", fallingEdge, e.fall);
        checkOutput("buttonOut_at_pulse", buttonOut, e.out);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks;
    int target;
    int j;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_buttonOut", buttonOut, 2'b00);
    checkOutput("reset_risingEdge", risingEdge, 2'b00);
    checkOutput("reset_fallingEdge", fallingEdge, 2'b00);
    checkOutput("reset_tick", tick, 1'b0);

    reset_n = 1'b1;
    enable  = 1'b1;
    ticks = 0;
    repeat (16) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    checkOutput("tick_count_enabled", ticks, 4);

    #1;
    enable = 1'b0;
    ticks = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    checkOutput("tick_count_disabled", ticks, 0);
    #1;
    enable = 1'b1;
    repeat (6) @(negedge clk);

    applyStimulus(2'b01);
    drainScoreboard();
    checkOutput("press_ch0", buttonOut[0], 1'b1);
    checkOutput("press_ch1_unchanged", buttonOut[1], 1'b0);

    applyStimulus(2'b00);
    drainScoreboard();
    checkOutput("release", buttonOut, 2'b00);

    for (int i = 0; i < 14; i++) begin
      buttonIn = (i % 2 == 0) ? 2'b01 : 2'b00;
      repeat (3) @(negedge clk);
      #1;
    end
    buttonIn = 2'b00;
    repeat (10) @(negedge clk);
    checkOutput("bounce_no_change", buttonOut, 2'b00);
    applyStimulus(2'b01);
    drainScoreboard();
    checkOutput("bounce_settled", buttonOut, 2'b01);

    applyStimulus(2'b00);
    drainScoreboard();
    applyStimulus(2'b11);
    drainScoreboard();
    checkOutput("simultaneous_press", buttonOut, 2'b11);
    applyStimulus(2'b00);
    drainScoreboard();
    checkOutput("simultaneous_release", buttonOut, 2'b00);

    applyStimulus(2'b10);
    drainScoreboard();

    @(negedge clk); #1;
    buttonIn = 2'b11;
    j = 2;
    while ((tphase + j) % THR != THR - 1) j++;
    target = cyc + j + THR + 1;
    while (cyc < target) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    modelOut = 2'b00;
    checkOutput("midreset_buttonOut", buttonOut, 2'b00);
    checkOutput("midreset_risingEdge", risingEdge, 2'b00);
    checkOutput("midreset_tick", tick, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    pushExpected(2'b11);
    drainScoreboard();
    checkOutput("post_reset_press", buttonOut, 2'b11);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
